serial_master: RTL

SERIAL_MASTER -- requirements
Module: serial_master

---
 rtl/serial_master.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_master.sv
// serial_master: 40-bit MSB-first serial register-access master ({rd, addr, data}).
// The readback path (ser_miso capture, rdata) is built only with SERIAL_MASTER_READBACK_EN.
module serial_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rd,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        ser_sclk,
  output logic        ser_sen_n,
  output logic        ser_mosi,
  input  logic        ser_miso
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST  = 6'd39;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  half_cnt_reg, half_cnt_next;
  logic        phase_reg, phase_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [39:0] tx_reg, tx_next;
  logic        done_reg, done_next;
  logic        frame_rd;
  logic        half_end;
  logic        bit_end;

  assign half_end = (half_cnt_reg == HALF_LAST);
  // Last cycle of a bit's high phase: slave data is sampled and MOSI advances.
  assign bit_end  = (state_reg == SHIFT) && phase_reg && half_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      phase_reg    <= 1'b0;
      bit_cnt_reg  <= '0;
      tx_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      half_cnt_reg <= half_cnt_next;
      phase_reg    <= phase_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    half_cnt_next = half_cnt_reg;
    phase_next    = phase_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = SHIFT;
          tx_next       = {frame_rd, addr, frame_rd ? 32'h0 : wdata};
          half_cnt_next = '0;
          phase_next    = 1'b0;
          bit_cnt_next  = '0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          half_cnt_next = '0;
          phase_next    = ~phase_reg;
          if (phase_reg) begin
            tx_next = {tx_reg[38:0], 1'b0};
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_next = '0;
              state_next   = HOLD;
            end else begin
              bit_cnt_next = bit_cnt_reg + 6'd1;
            end
          end
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end
      HOLD: begin
        if (half_end) begin
          half_cnt_next = '0;
          state_next    = GAP;
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end
      GAP: begin
        if (half_end) begin
          half_cnt_next = '0;
          state_next    = IDLE;
          done_next     = 1'b1;
        end else begin
          half_cnt_next = half_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SERIAL_MASTER_READBACK_EN
  logic        rd_reg;
  logic [31:0] rx_reg;
  logic [31:0] rdata_reg;

  assign frame_rd = rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_reg    <= 1'b0;
      rx_reg    <= '0;
      rdata_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        rd_reg <= rd;
      end
      // Header bits (index 0..7) carry no readback data.
      if (bit_end && rd_reg && (bit_cnt_reg >= 6'd8)) begin
        rx_reg <= {rx_reg[30:0], ser_miso};
      end
      if (done_next && rd_reg) begin
        rdata_reg <= rx_reg;
      end
    end
  end

  assign rdata = rdata_reg;
`else
  logic [1:0] unused_inputs;

  assign unused_inputs = {rd, ser_miso};
  assign frame_rd      = 1'b0;
  assign rdata         = '0;
`endif

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign ser_sclk  = (state_reg == SHIFT) && phase_reg;
  assign ser_sen_n = !((state_reg == SHIFT) || (state_reg == HOLD));
  assign ser_mosi  = tx_reg[39];

endmodule
